serial_alu_core: RTL and testbench
==================================

Name: serial_alu_core

Overview:
Bit-serial arithmetic back end that consumes the operand triple produced by the operand-extension stage: OPA, pre-transformed OPB, and carry-in c. Computes OPA + OPB + c one bit per clock, LSB first. Returns result plus carry, signed-overflow and zero flags. Uses valid/ready handshakes on both sides so it sits between the operand stage and the register-writeback logic.

Parameters:
WIDTH, 8, operand/result width in bits (minimum 2).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand triple valid.
in_ready  out  1  core can accept operands; high only in IDLE.
opa  in  WIDTH  operand A, already passed through the extension stage.
opb  in  WIDTH  operand B, already transformed (B, ~B or 0).
cin  in  1  carry-in from the extension stage.
out_valid  out  1  result/flags valid.
out_ready  in  1  downstream accepts result.
res  out  WIDTH  sum opa+opb+cin, modulo 2^WIDTH.
cout  out  1  carry out of MSB.
ovf  out  1  signed overflow.
zero  out  1  res == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- On a clk edge with rst=1:
  - state goes to IDLE and the bit counter clears.
  - shift registers, carry register, res, cout, ovf, zero and out_valid all go to 0.
  - in_ready=1 from the following cycle.
  - rst has priority over every other event, including mid-SHIFT and in DONE. No partial result is ever presented.
- in_ready and out_valid are decoded directly from state registers. There is no combinational path from in_valid or out_ready to either.
- States:
  - IDLE: in_ready=1, out_valid=0. If in_valid=1 at the edge:
    - capture opa, opb into shift registers A_sr, B_sr.
    - capture cin into carry register, capture sign bits opa[MSB], opb[MSB].
    - clear counter, go to SHIFT.
    - If in_valid=0, stay in IDLE.
  - SHIFT: in_ready=0, out_valid=0. Each edge:
    - compute sum = A_sr[0]^B_sr[0]^carry and the full-adder carry.
    - shift A_sr, B_sr right; shift sum into the MSB of the result shift register.
    - update carry; counter+1.
    - On the edge where counter == WIDTH-1: load res, cout (final carry), ovf and zero, then go to DONE.
    - Total SHIFT duration is exactly WIDTH cycles.
    - in_valid changes during SHIFT are ignored.
  - DONE: out_valid=1, in_ready=0. If out_ready=1 at the edge, go to IDLE; otherwise hold. Held values are stable.
- Flag rules:
  - ovf = (opa[MSB]==opb[MSB]) && (res[MSB]!=opa[MSB]), using the captured signs. Valid uniformly for add, subtract (opb=~B, cin=1), increment and pass.
  - zero = ~|res.
  - cout is the raw MSB carry, so subtract with no borrow gives cout=1.
- Latency: the acceptance edge is t0, and out_valid rises after edge t0+WIDTH.
- Throughput: one op per WIDTH+2 cycles minimum. The DONE->IDLE transition costs one bubble, so in_ready is never high in the same cycle as out_valid.
- res/cout/ovf/zero keep their last values after the output handshake until the next DONE load. out_valid=0 marks them stale.
- Width: all arithmetic is unsigned modulo 2^WIDTH. The counter is clog2(WIDTH) bits and never wraps past WIDTH-1.

Decomposition:
- Shared package alu_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - ALU_WIDTH=8 default constant.
  - CNT_W=$clog2(ALU_WIDTH).
  - operation-select encodings 2'b00 add, 2'b01 sub, 2'b10 inc, 2'b11 pass, for bench use.
- One natural sub-module: full_adder_bit, combinational 1-bit full adder with inputs a, b, ci and outputs s, co, instantiated once in the SHIFT datapath.

Test Plan:
1. Add: opa=0x3C, opb=0x05, cin=0 -> res=0x41, cout=0, ovf=0, zero=0. out_valid rises 8 cycles after acceptance.
2. Subtract equal: opa=0x05, opb=0xFA, cin=1 -> res=0x00, cout=1, ovf=0, zero=1.
3. Signed overflow: opa=0x7F, opb=0x01, cin=0 -> res=0x80, cout=0, ovf=1, zero=0. Also opa=0x80, opb=0xFF(~0x00), cin=1 -> res=0x80, cout=1, ovf=0.
4. Increment wrap: opa=0xFF, opb=0x00, cin=1 -> res=0x00, cout=1, ovf=0, zero=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: out_valid stays 1, res/flags stay stable, in_ready stays 0, and in_valid pulses are ignored. Then out_ready=1 -> IDLE next cycle, in_ready=1.
6. Reset mid-operation: assert rst for 1 cycle after 3 SHIFT cycles -> state IDLE, out_valid=0, res=0, flags=0. The next op (0x10+0x20, cin=0) gives res=0x30 with correct latency.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the bit-serial ALU back end.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Controller states of the serial core
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ALU_WIDTH = 8;
  localparam int CNT_W     = $clog2(ALU_WIDTH);

  // Operation encodings used by the operand-extension stage
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/serial_alu_core_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_core_if
// Description : Operand-in / result-out handshake bundle of the serial ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_alu_core_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;
  logic             zero;

  // Operand producer / result consumer side
  modport master (
    output in_valid, opa, opb, cin, out_ready,
    input  in_ready, out_valid, res, cout, ovf, zero
  );

  // ALU core side
  modport slave (
    input  in_valid, opa, opb, cin, out_ready,
    output in_ready, out_valid, res, cout, ovf, zero
  );

endinterface : serial_alu_core_if
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bit
// Description : Combinational one-bit full adder.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
  input  wire logic a,
  input  wire logic b,
  input  wire logic ci,
  output logic      s,
  output logic      co
);

  // Sum and majority carry
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : full_adder_bit
`default_nettype wire

// File: rtl/serial_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_core
// Description : Bit-serial adder back end, LSB first, with carry, signed
//               overflow and zero flags and valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_alu_core_if.slave   bus
);

  localparam int             CNT_WL   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_WL-1:0] LAST_CNT = CNT_WL'(WIDTH - 1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_sr_q, b_sr_q, r_sr_q;
  logic                carry_q;
  logic                sign_a_q, sign_b_q;
  logic [CNT_WL-1:0]   cnt_q;
  logic [WIDTH-1:0]    res_q;
  logic                cout_q, ovf_q, zero_q;

  logic                w_sum, w_co, w_last;
  logic [WIDTH-1:0]    w_res_shift;

  full_adder_bit u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (w_sum),
    .co (w_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB has arrived at bit 0
  assign w_res_shift = (r_sr_q >> 1) | {w_sum, {(WIDTH-1){1'b0}}};
  assign w_last      = (cnt_q == LAST_CNT);

  // Handshake outputs are pure state decodes, no input-to-output paths
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res       = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = SHIFT;
      SHIFT:   if (w_last)        state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Operand capture, serial add and result/flag load
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      carry_q  <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr_q   <= bus.opa;
            b_sr_q   <= bus.opb;
            r_sr_q   <= '0;
            carry_q  <= bus.cin;
            sign_a_q <= bus.opa[WIDTH-1];
            sign_b_q <= bus.opb[WIDTH-1];
            cnt_q    <= '0;
          end
        end
        SHIFT: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          r_sr_q  <= w_res_shift;
          carry_q <= w_co;
          if (w_last) begin
            // Counter holds at WIDTH-1 rather than wrapping
            res_q  <= w_res_shift;
            cout_q <= w_co;
            ovf_q  <= (sign_a_q == sign_b_q) && (w_sum != sign_a_q);
            zero_q <= ~|w_res_shift;
          end else begin
            cnt_q <= cnt_q + CNT_WL'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_alu_core
`default_nettype wire

// File: tb/tb_serial_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_alu_core
// Description : Directed self-checking bench for serial_alu_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_alu_core;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_alu_core_if #(.WIDTH(W)) bus ();

  serial_alu_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operand-extension model: returns {cin, opb}
  function automatic logic [W:0] xform(input logic [1:0] op, input logic [W-1:0] b);
    case (op)
      OP_ADD:  xform = {1'b0, b};
      OP_SUB:  xform = {1'b1, ~b};
      OP_INC:  xform = {1'b1, {W{1'b0}}};
      default: xform = {1'b0, {W{1'b0}}};
    endcase
  endfunction

  // Present operands at a falling edge; returns #1 after the acceptance edge
  task automatic start_op(input string tag, input logic [W-1:0] a, input logic [1:0] op,
                          input logic [W-1:0] b);
    logic [W:0] x;
    x = xform(op, b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opa      = a;
    bus.opb      = x[W-1:0];
    bus.cin      = x[W];
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(bus.in_ready), 32'(1'b0));
  endtask

  // out_valid must be low through edge t0+W-1 and high after edge t0+W
  task automatic wait_done(input string tag);
    for (int k = 1; k < W; k++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_early"}, 32'(bus.out_valid), 32'(1'b0));
    @(posedge clk);
    #1;
    check({tag, "_lat"}, 32'(bus.out_valid), 32'(1'b1));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] r, input logic c,
                              input logic v, input logic z);
    check({tag, "_res"},  32'(bus.res),  32'(r));
    check({tag, "_cout"}, 32'(bus.cout), 32'(c));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(v));
    check({tag, "_zero"}, 32'(bus.zero), 32'(z));
  endtask

  // Output handshake: IDLE with in_ready high right after the accepting edge
  task automatic accept(input string tag, input logic [W-1:0] r);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(bus.out_valid), 32'(1'b0));
    check({tag, "_ir_rise"}, 32'(bus.in_ready),  32'(1'b1));
    check({tag, "_held"},    32'(bus.res),       32'(r));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opa       = '0;
    bus.opb       = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'(1'b1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
    check("rst_res",       32'(bus.res),       32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Add
    start_op("add", 8'h3C, OP_ADD, 8'h05);
    wait_done("add");
    check_result("add", 8'h41, 1'b0, 1'b0, 1'b0);
    accept("add", 8'h41);

    // Subtract equal operands: no borrow, cout=1
    start_op("sub", 8'h05, OP_SUB, 8'h05);
    wait_done("sub");
    check_result("sub", 8'h00, 1'b1, 1'b0, 1'b1);
    accept("sub", 8'h00);

    // Positive overflow
    start_op("ovf", 8'h7F, OP_ADD, 8'h01);
    wait_done("ovf");
    check_result("ovf", 8'h80, 1'b0, 1'b1, 1'b0);
    accept("ovf", 8'h80);

    // 0x80 - 0: same signs, no overflow
    start_op("sub80", 8'h80, OP_SUB, 8'h00);
    wait_done("sub80");
    check_result("sub80", 8'h80, 1'b1, 1'b0, 1'b0);
    accept("sub80", 8'h80);

    // Increment wrap
    start_op("inc", 8'hFF, OP_INC, 8'h00);
    wait_done("inc");
    check_result("inc", 8'h00, 1'b1, 1'b0, 1'b1);
    accept("inc", 8'h00);

    // Backpressure: 0xC0 + 0x50 = 0x110
    start_op("bp", 8'hC0, OP_ADD, 8'h50);
    wait_done("bp");
    check_result("bp", 8'h10, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opa      = 8'h11 + 8'(k);
      bus.opb      = 8'h22;
      bus.cin      = 1'b1;
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'(1'b1));
      check("bp_in_ready",  32'(bus.in_ready),  32'(1'b0));
      check("bp_res",       32'(bus.res),       32'(8'h10));
      check("bp_cout",      32'(bus.cout),      32'(1'b1));
    end
    bus.in_valid = 1'b0;
    accept("bp", 8'h10);

    // Reset after three SHIFT cycles
    start_op("mid", 8'h55, OP_ADD, 8'h0F);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'(1'b0));
    check("mrst_in_ready",  32'(bus.in_ready),  32'(1'b1));
    check("mrst_res",       32'(bus.res),       32'(0));
    check("mrst_cout",      32'(bus.cout),      32'(1'b0));
    check("mrst_ovf",       32'(bus.ovf),       32'(1'b0));
    check("mrst_zero",      32'(bus.zero),      32'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Clean operation after the aborted one
    start_op("post", 8'h10, OP_ADD, 8'h20);
    wait_done("post");
    check_result("post", 8'h30, 1'b0, 1'b0, 1'b0);
    accept("post", 8'h30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_alu_core
`default_nettype wire
